// File: rtl/lcd_cmd_sequencer.sv
// i8080 bus front end: synchronizes CS/RS/We/Data into CLK, decodes a DCS-style
// command set and packs RAMWR byte pairs into RGB565 pixels with window tracking.
module lcd_cmd_sequencer #(
  parameter int unsigned H_ACTIVE   = 800,
  parameter int unsigned V_ACTIVE   = 480,
  parameter logic [7:0]  BL_DEFAULT = 8'hFF
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        J80_CS,
  input  logic        J80_RS,
  input  logic        J80_We,
  input  logic [7:0]  J80_Data,
  input  logic        FIFO_Full,
  output logic        FIFOWe,
  output logic [15:0] FIFO_Data,
  output logic [10:0] PixX,
  output logic [10:0] PixY,
  output logic        FrameStart,
  output logic        FrameDone,
  output logic        DispOn,
  output logic [7:0]  BL_Level,
  output logic        Overflow
);

  localparam logic [10:0] HMax = 11'(H_ACTIVE - 1);
  localparam logic [10:0] VMax = 11'(V_ACTIVE - 1);

  typedef enum logic [1:0] {StIdle, StParam, StPixHi, StPixLo} state_e;
  typedef enum logic [1:0] {TgtCol, TgtPage, TgtBl} tgt_e;

  // Bus synchronizers; RS/Data get a third stage to stay aligned with we_s3.
  logic       cs_s1, cs_s2;
  logic       we_s1, we_s2, we_s3;
  logic       rs_s1, rs_s2, rs_s3;
  logic [7:0] data_s1, data_s2, data_s3;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      cs_s1   <= 1'b1;
      cs_s2   <= 1'b1;
      we_s1   <= 1'b0;
      we_s2   <= 1'b0;
      we_s3   <= 1'b0;
      rs_s1   <= 1'b0;
      rs_s2   <= 1'b0;
      rs_s3   <= 1'b0;
      data_s1 <= 8'h00;
      data_s2 <= 8'h00;
      data_s3 <= 8'h00;
    end else begin
      cs_s1   <= J80_CS;
      cs_s2   <= cs_s1;
      we_s1   <= J80_We;
      we_s2   <= we_s1;
      we_s3   <= we_s2;
      rs_s1   <= J80_RS;
      rs_s2   <= rs_s1;
      rs_s3   <= rs_s2;
      data_s1 <= J80_Data;
      data_s2 <= data_s1;
      data_s3 <= data_s2;
    end
  end

  logic ev;
  assign ev = we_s3 & ~we_s2 & ~cs_s2;

  state_e      state_q, state_d;
  tgt_e        tgt_q, tgt_d;
  logic [1:0]  idx_q, idx_d;
  logic [2:0]  p0_q, p0_d, p2_q, p2_d;
  logic [7:0]  p1_q, p1_d;
  logic [10:0] xs_q, xs_d, xe_q, xe_d, ys_q, ys_d, ye_q, ye_d;
  logic [10:0] wxs_q, wxs_d, wxe_q, wxe_d, wys_q, wys_d, wye_q, wye_d;
  logic [10:0] cur_x_q, cur_x_d, cur_y_q, cur_y_d;
  logic [10:0] pix_x_q, pix_x_d, pix_y_q, pix_y_d;
  logic [7:0]  hi_q, hi_d;
  logic [15:0] fifo_data_q, fifo_data_d;
  logic        fifo_we_q, fifo_we_d;
  logic        fs_q, fs_d, fd_q, fd_d;
  logic        armed_q, armed_d;
  logic        disp_q, disp_d;
  logic [7:0]  bl_q, bl_d;
  logic        ovf_q, ovf_d;

  logic [10:0] eff_xs, eff_xe, eff_ys, eff_ye;

  // Window clamped to the active area; an inverted range collapses to its start.
  always_comb begin
    eff_xs = (xs_q > HMax) ? HMax : xs_q;
    eff_xe = (xe_q > HMax) ? HMax : xe_q;
    if (eff_xe < eff_xs) eff_xe = eff_xs;
    eff_ys = (ys_q > VMax) ? VMax : ys_q;
    eff_ye = (ye_q > VMax) ? VMax : ye_q;
    if (eff_ye < eff_ys) eff_ye = eff_ys;
  end

  always_comb begin
    state_d     = state_q;
    tgt_d       = tgt_q;
    idx_d       = idx_q;
    p0_d        = p0_q;
    p1_d        = p1_q;
    p2_d        = p2_q;
    xs_d        = xs_q;
    xe_d        = xe_q;
    ys_d        = ys_q;
    ye_d        = ye_q;
    wxs_d       = wxs_q;
    wxe_d       = wxe_q;
    wys_d       = wys_q;
    wye_d       = wye_q;
    cur_x_d     = cur_x_q;
    cur_y_d     = cur_y_q;
    pix_x_d     = pix_x_q;
    pix_y_d     = pix_y_q;
    hi_d        = hi_q;
    fifo_data_d = fifo_data_q;
    fifo_we_d   = 1'b0;
    fs_d        = 1'b0;
    fd_d        = 1'b0;
    armed_d     = armed_q;
    disp_d      = disp_q;
    bl_d        = bl_q;
    ovf_d       = ovf_q;

    if (ev) begin
      if (!rs_s3) begin
        state_d = StIdle;
        idx_d   = 2'd0;
        hi_d    = 8'h00;
        case (data_s3)
          8'h2A: begin state_d = StParam; tgt_d = TgtCol;  end
          8'h2B: begin state_d = StParam; tgt_d = TgtPage; end
          8'h51: begin state_d = StParam; tgt_d = TgtBl;   end
          8'h2C: begin
            state_d = StPixHi;
            wxs_d   = eff_xs;
            wxe_d   = eff_xe;
            wys_d   = eff_ys;
            wye_d   = eff_ye;
            cur_x_d = eff_xs;
            cur_y_d = eff_ys;
            pix_x_d = eff_xs;
            pix_y_d = eff_ys;
            ovf_d   = 1'b0;
            armed_d = 1'b1;
          end
          8'h28: disp_d = 1'b0;
          8'h29: disp_d = 1'b1;
          8'h01: begin
            tgt_d       = TgtCol;
            p0_d        = 3'd0;
            p1_d        = 8'h00;
            p2_d        = 3'd0;
            xs_d        = 11'd0;
            ys_d        = 11'd0;
            xe_d        = HMax;
            ye_d        = VMax;
            wxs_d       = 11'd0;
            wys_d       = 11'd0;
            wxe_d       = HMax;
            wye_d       = VMax;
            cur_x_d     = 11'd0;
            cur_y_d     = 11'd0;
            pix_x_d     = 11'd0;
            pix_y_d     = 11'd0;
            fifo_data_d = 16'h0000;
            armed_d     = 1'b0;
            disp_d      = 1'b0;
            bl_d        = BL_DEFAULT;
            ovf_d       = 1'b0;
          end
          default: ;
        endcase
      end else begin
        case (state_q)
          StParam: begin
            if (tgt_q == TgtBl) begin
              bl_d    = data_s3;
              state_d = StIdle;
            end else begin
              idx_d = idx_q + 2'd1;
              case (idx_q)
                2'd0: p0_d = data_s3[2:0];
                2'd1: p1_d = data_s3;
                2'd2: p2_d = data_s3[2:0];
                default: begin
                  state_d = StIdle;
                  if (tgt_q == TgtCol) begin
                    xs_d = {p0_q, p1_q};
                    xe_d = {p2_q, data_s3};
                  end else begin
                    ys_d = {p0_q, p1_q};
                    ye_d = {p2_q, data_s3};
                  end
                end
              endcase
            end
          end
          StPixHi: begin
            hi_d    = data_s3;
            state_d = StPixLo;
          end
          StPixLo: begin
            state_d = StPixHi;
            fs_d    = armed_q;
            armed_d = 1'b0;
            if (!FIFO_Full) begin
              fifo_we_d   = 1'b1;
              fifo_data_d = {hi_q, data_s3};
              pix_x_d     = cur_x_q;
              pix_y_d     = cur_y_q;
            end else begin
              ovf_d = 1'b1;
            end
            if (cur_x_q == wxe_q) begin
              cur_x_d = wxs_q;
              if (cur_y_q == wye_q) begin
                cur_y_d = wys_q;
                fd_d    = 1'b1;
              end else begin
                cur_y_d = cur_y_q + 11'd1;
              end
            end else begin
              cur_x_d = cur_x_q + 11'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= StIdle;
      tgt_q       <= TgtCol;
      idx_q       <= 2'd0;
      p0_q        <= 3'd0;
      p1_q        <= 8'h00;
      p2_q        <= 3'd0;
      xs_q        <= 11'd0;
      ys_q        <= 11'd0;
      xe_q        <= HMax;
      ye_q        <= VMax;
      wxs_q       <= 11'd0;
      wys_q       <= 11'd0;
      wxe_q       <= HMax;
      wye_q       <= VMax;
      cur_x_q     <= 11'd0;
      cur_y_q     <= 11'd0;
      pix_x_q     <= 11'd0;
      pix_y_q     <= 11'd0;
      hi_q        <= 8'h00;
      fifo_data_q <= 16'h0000;
      fifo_we_q   <= 1'b0;
      fs_q        <= 1'b0;
      fd_q        <= 1'b0;
      armed_q     <= 1'b0;
      disp_q      <= 1'b0;
      bl_q        <= BL_DEFAULT;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      tgt_q       <= tgt_d;
      idx_q       <= idx_d;
      p0_q        <= p0_d;
      p1_q        <= p1_d;
      p2_q        <= p2_d;
      xs_q        <= xs_d;
      ys_q        <= ys_d;
      xe_q        <= xe_d;
      ye_q        <= ye_d;
      wxs_q       <= wxs_d;
      wys_q       <= wys_d;
      wxe_q       <= wxe_d;
      wye_q       <= wye_d;
      cur_x_q     <= cur_x_d;
      cur_y_q     <= cur_y_d;
      pix_x_q     <= pix_x_d;
      pix_y_q     <= pix_y_d;
      hi_q        <= hi_d;
      fifo_data_q <= fifo_data_d;
      fifo_we_q   <= fifo_we_d;
      fs_q        <= fs_d;
      fd_q        <= fd_d;
      armed_q     <= armed_d;
      disp_q      <= disp_d;
      bl_q        <= bl_d;
      ovf_q       <= ovf_d;
    end
  end

  assign FIFOWe     = fifo_we_q;
  assign FIFO_Data  = fifo_data_q;
  assign PixX       = pix_x_q;
  assign PixY       = pix_y_q;
  assign FrameStart = fs_q;
  assign FrameDone  = fd_q;
  assign DispOn     = disp_q;
  assign BL_Level   = bl_q;
  assign Overflow   = ovf_q;

endmodule

// File: tb/tb_lcd_cmd_sequencer.sv
// Directed bench for lcd_cmd_sequencer: drives i8080 writes and checks the
// recorded FIFO pixel stream and control registers against hand-computed values.
module tb_lcd_cmd_sequencer;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        J80_CS, J80_RS, J80_We;
  logic [7:0]  J80_Data;
  logic        FIFO_Full;
  logic        FIFOWe;
  logic [15:0] FIFO_Data;
  logic [10:0] PixX, PixY;
  logic        FrameStart, FrameDone, DispOn, Overflow;
  logic [7:0]  BL_Level;

  lcd_cmd_sequencer dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .J80_CS    (J80_CS),
    .J80_RS    (J80_RS),
    .J80_We    (J80_We),
    .J80_Data  (J80_Data),
    .FIFO_Full (FIFO_Full),
    .FIFOWe    (FIFOWe),
    .FIFO_Data (FIFO_Data),
    .PixX      (PixX),
    .PixY      (PixY),
    .FrameStart(FrameStart),
    .FrameDone (FrameDone),
    .DispOn    (DispOn),
    .BL_Level  (BL_Level),
    .Overflow  (Overflow)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [15:0] d;
    logic [10:0] x;
    logic [10:0] y;
    logic        fs;
    logic        fd;
  } pix_t;

  pix_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Every FIFO write is recorded with its position and frame flags.
  always @(negedge CLK) begin
    if (FIFOWe) q.push_back('{d: FIFO_Data, x: PixX, y: PixY, fs: FrameStart, fd: FrameDone});
  end

  task automatic bus_wr(input logic rs, input logic [7:0] d, input logic cs);
    @(negedge CLK);
    J80_CS   = cs;
    J80_RS   = rs;
    J80_Data = d;
    J80_We   = 1'b1;
    repeat (3) @(negedge CLK);
    J80_We = 1'b0;
    repeat (6) @(negedge CLK);
    J80_CS = 1'b1;
    @(negedge CLK);
  endtask

  task automatic cmd(input logic [7:0] c);
    bus_wr(1'b0, c, 1'b0);
  endtask

  task automatic dat(input logic [7:0] d);
    bus_wr(1'b1, d, 1'b0);
  endtask

  task automatic clear_q;
    #1 q.delete();
  endtask

  task automatic check_stream(input string name, input pix_t exp[]);
    n_checks++;
    if (q.size() !== exp.size()) begin
      $display("FAIL %s count: got %0d pixels, expected %0d", name, q.size(), exp.size());
    end else begin
      n_pass++;
      foreach (exp[i]) begin
        n_checks++;
        if (q[i] !== exp[i])
          $display("FAIL %s pixel %0d: got d=%h x=%0d y=%0d fs=%b fd=%b, expected d=%h x=%0d y=%0d fs=%b fd=%b",
                   name, i, q[i].d, q[i].x, q[i].y, q[i].fs, q[i].fd,
                   exp[i].d, exp[i].x, exp[i].y, exp[i].fs, exp[i].fd);
        else n_pass++;
      end
    end
  endtask

  task automatic test_reset;
    repeat (20) @(negedge CLK);
    n_checks++;
    if (DispOn !== 1'b0) $display("FAIL reset_dispon: got %b, expected 0", DispOn);
    else n_pass++;
    n_checks++;
    if (BL_Level !== 8'hFF) $display("FAIL reset_bl: got %h, expected ff", BL_Level);
    else n_pass++;
    n_checks++;
    if (Overflow !== 1'b0) $display("FAIL reset_ovf: got %b, expected 0", Overflow);
    else n_pass++;
    n_checks++;
    if (q.size() !== 0) $display("FAIL reset_fifowe: got %0d writes, expected 0", q.size());
    else n_pass++;
    n_checks++;
    if ({PixX, PixY} !== 22'd0) $display("FAIL reset_pos: got (%0d,%0d), expected (0,0)", PixX, PixY);
    else n_pass++;
  endtask

  task automatic test_window;
    pix_t e1[] = '{'{16'h1234, 11'd0, 11'd0, 1'b1, 1'b0},
                   '{16'h5678, 11'd1, 11'd0, 1'b0, 1'b0},
                   '{16'h9ABC, 11'd0, 11'd1, 1'b0, 1'b0},
                   '{16'hDEF0, 11'd1, 11'd1, 1'b0, 1'b1}};
    pix_t e2[] = '{'{16'h1122, 11'd0, 11'd0, 1'b0, 1'b0}};
    logic [7:0] bytes[8] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
    clear_q();
    cmd(8'h2A); dat(8'h00); dat(8'h00); dat(8'h00); dat(8'h01);
    cmd(8'h2B); dat(8'h00); dat(8'h00); dat(8'h00); dat(8'h01);
    cmd(8'h2C);
    foreach (bytes[i]) dat(bytes[i]);
    check_stream("window2x2", e1);
    clear_q();
    dat(8'h11); dat(8'h22);
    check_stream("window_wrap", e2);
  endtask

  task automatic test_disp_bl;
    cmd(8'h29);
    n_checks++;
    if (DispOn !== 1'b1) $display("FAIL disp_on: got %b, expected 1", DispOn);
    else n_pass++;
    cmd(8'h51);
    n_checks++;
    if (BL_Level !== 8'hFF) $display("FAIL bl_before_data: got %h, expected ff", BL_Level);
    else n_pass++;
    dat(8'h40);
    n_checks++;
    if (BL_Level !== 8'h40) $display("FAIL bl_set: got %h, expected 40", BL_Level);
    else n_pass++;
    dat(8'h77);  // extra byte in IDLE is ignored
    n_checks++;
    if (BL_Level !== 8'h40) $display("FAIL bl_extra: got %h, expected 40", BL_Level);
    else n_pass++;
    cmd(8'h28);
    n_checks++;
    if (DispOn !== 1'b0) $display("FAIL disp_off: got %b, expected 0", DispOn);
    else n_pass++;
  endtask

  task automatic test_cs_ignore;
    bus_wr(1'b0, 8'h29, 1'b1);
    n_checks++;
    if (DispOn !== 1'b0) $display("FAIL cs_ignore: got %b, expected 0", DispOn);
    else n_pass++;
  endtask

  task automatic test_overflow;
    pix_t e[] = '{'{16'h0102, 11'd0, 11'd0, 1'b1, 1'b0},
                  '{16'h0506, 11'd2, 11'd0, 1'b0, 1'b0}};
    cmd(8'h29);
    cmd(8'h01);
    n_checks++;
    if ({DispOn, BL_Level} !== {1'b0, 8'hFF})
      $display("FAIL swreset: got disp=%b bl=%h, expected disp=0 bl=ff", DispOn, BL_Level);
    else n_pass++;
    clear_q();
    cmd(8'h2C);
    dat(8'h01); dat(8'h02);
    n_checks++;
    if (Overflow !== 1'b0) $display("FAIL ovf_before: got %b, expected 0", Overflow);
    else n_pass++;
    FIFO_Full = 1'b1;
    dat(8'h03); dat(8'h04);
    FIFO_Full = 1'b0;
    dat(8'h05); dat(8'h06);
    check_stream("overflow", e);
    n_checks++;
    if (Overflow !== 1'b1) $display("FAIL ovf_set: got %b, expected 1", Overflow);
    else n_pass++;
    cmd(8'h2C);
    n_checks++;
    if (Overflow !== 1'b0) $display("FAIL ovf_clear: got %b, expected 0", Overflow);
    else n_pass++;
  endtask

  task automatic test_clamp;
    pix_t e[] = '{'{16'hAA55, 11'd799, 11'd0, 1'b1, 1'b0},
                  '{16'h55AA, 11'd799, 11'd1, 1'b0, 1'b0}};
    clear_q();
    cmd(8'h2A); dat(8'h03); dat(8'hFF); dat(8'h00); dat(8'h05);
    cmd(8'h2C);
    dat(8'hAA); dat(8'h55); dat(8'h55); dat(8'hAA);
    check_stream("clamp", e);
  endtask

  task automatic test_abort;
    pix_t e[] = '{'{16'hCDEF, 11'd0, 11'd0, 1'b1, 1'b0}};
    cmd(8'h01);
    clear_q();
    cmd(8'h2C);
    dat(8'hAB);
    cmd(8'h00);
    dat(8'h99);  // data after an unknown command is ignored
    cmd(8'h2C);
    dat(8'hCD); dat(8'hEF);
    check_stream("abort", e);
  endtask

  initial begin
    nRST      = 1'b0;
    J80_CS    = 1'b1;
    J80_RS    = 1'b0;
    J80_We    = 1'b0;
    J80_Data  = 8'h00;
    FIFO_Full = 1'b0;
    repeat (3) @(negedge CLK);
    nRST = 1'b1;
    test_reset();
    test_window();
    test_disp_bl();
    test_cs_ignore();
    test_overflow();
    test_clamp();
    test_abort();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
